// File: rtl/wakeup_broadcaster.sv
// wakeup_broadcaster: merges FU completions into oldest-first issue-queue wakeup broadcasts
module wakeup_broadcaster #(
  parameter int NUM_FU           = 4,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int PREG_BITS        = 7,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_FU-1:0]                          fu_done_valid,
  input  logic [NUM_FU-1:0][PREG_BITS-1:0]           fu_done_pdst,
  output logic                                       fu_ready,
  output logic [NUM_WAKEUP_PORTS-1:0]                wakeup_valid,
  output logic [NUM_WAKEUP_PORTS-1:0][PREG_BITS-1:0] wakeup_pdst,
  input  logic                                       flush_pipelines
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [PREG_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [NUM_FU-1:0] acc;
  int rank [NUM_FU];
  int n, take, pops, pushes;
  logic [NUM_WAKEUP_PORTS-1:0] nv;
  logic [NUM_WAKEUP_PORTS-1:0][PREG_BITS-1:0] np;

  assign fu_ready = count <= CW'(FIFO_DEPTH - NUM_FU);

  // rank accepted completions behind the FIFO contents and route the oldest candidates to the ports
  always_comb begin
    n = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      acc[k] = fu_done_valid[k] & fu_ready & ~flush_pipelines & (|fu_done_pdst[k]);
      rank[k] = n;
      n = n + (acc[k] ? 1 : 0);
    end
    take = int'(count) + n < NUM_WAKEUP_PORTS ? int'(count) + n : NUM_WAKEUP_PORTS;
    pops = int'(count) < NUM_WAKEUP_PORTS ? int'(count) : NUM_WAKEUP_PORTS;
    pushes = n - (take - pops);
    for (int i = 0; i < NUM_WAKEUP_PORTS; i++) begin
      nv[i] = i < take;
      np[i] = wakeup_pdst[i];
      if (i < int'(count))
        np[i] = mem[head + PW'(i)];
      for (int k = 0; k < NUM_FU; k++)
        if (acc[k] && i >= int'(count) && rank[k] == i - int'(count))
          np[i] = fu_done_pdst[k];
    end
  end

  // pointers, occupancy and registered ports; flush drops everything in flight but keeps tags
  always_ff @(posedge clk) begin
    if (reset || flush_pipelines) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      wakeup_valid <= '0;
      if (reset)
        wakeup_pdst <= '0;
    end else begin
      head <= head + PW'(pops);
      tail <= tail + PW'(pushes);
      count <= count + CW'(n) - CW'(take);
      wakeup_valid <= nv;
      wakeup_pdst <= np;
    end
  end

  // completions that did not fit on a port go to the tail in FU index order
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++)
      if (!reset && acc[k] && rank[k] >= take - pops)
        mem[tail + PW'(rank[k] - take + pops)] <= fu_done_pdst[k];
  end
endmodule

// File: tb/tb_wakeup_broadcaster.sv
// tb_wakeup_broadcaster: directed checks of wakeup ordering, backpressure, zero tag and flush
module tb_wakeup_broadcaster;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_pipelines = 1'b0;
  logic fu_ready;
  logic [3:0] fu_done_valid = '0;
  logic [3:0][6:0] fu_done_pdst = '0;
  logic [1:0] wakeup_valid;
  logic [1:0][6:0] wakeup_pdst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_tags [24];
  int bp_count [10] = '{2, 4, 6, 4, 6, 4, 6, 4, 6, 4};
  int ne;

  always #5 clk = ~clk;

  wakeup_broadcaster dut (
    .clk(clk),
    .reset(reset),
    .fu_done_valid(fu_done_valid),
    .fu_done_pdst(fu_done_pdst),
    .fu_ready(fu_ready),
    .wakeup_valid(wakeup_valid),
    .wakeup_pdst(wakeup_pdst),
    .flush_pipelines(flush_pipelines)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    fu_done_valid = v;
    fu_done_pdst = {p3, p2, p1, p0};
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      drive(4'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      tick();
    end
    reset = 1'b0;
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("rst_valid", 32'(wakeup_valid), 0);
    chk("rst_pdst", 32'(wakeup_pdst), 0);
    chk("rst_ready", 32'(fu_ready), 1);
    chk("rst_count", 32'(dut.count), 0);

    drive(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
    tick();
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("single_valid", 32'(wakeup_valid), 1);
    chk("single_p0", 32'(wakeup_pdst[0]), 5);
    tick();
    chk("single_idle", 32'(wakeup_valid), 0);

    drive(4'b1111, 7'd10, 7'd11, 7'd12, 7'd13);
    tick();
    chk("burst1_valid", 32'(wakeup_valid), 3);
    chk("burst1_p0", 32'(wakeup_pdst[0]), 10);
    chk("burst1_p1", 32'(wakeup_pdst[1]), 11);
    chk("burst1_count", 32'(dut.count), 2);
    drive(4'b0010, 7'd0, 7'd20, 7'd0, 7'd0);
    tick();
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("burst2_valid", 32'(wakeup_valid), 3);
    chk("burst2_p0", 32'(wakeup_pdst[0]), 12);
    chk("burst2_p1", 32'(wakeup_pdst[1]), 13);
    chk("burst2_count", 32'(dut.count), 1);
    tick();
    chk("burst3_valid", 32'(wakeup_valid), 1);
    chk("burst3_p0", 32'(wakeup_pdst[0]), 20);
    chk("burst3_count", 32'(dut.count), 0);
    tick();
    chk("burst4_idle", 32'(wakeup_valid), 0);

    ne = 0;
    for (int c = 0; c < 10; c++)
      if (c < 3 || c % 2 == 0)
        for (int k = 0; k < 4; k++) begin
          exp_tags[ne] = 7'(16 + 4 * c + k);
          ne++;
        end
    for (int c = 0; c < 10; c++) begin
      drive(4'b1111, 7'(16 + 4 * c), 7'(17 + 4 * c), 7'(18 + 4 * c), 7'(19 + 4 * c));
      chk($sformatf("bp_ready%0d", c), 32'(fu_ready), 32'(c < 3 || c % 2 == 0));
      tick();
      chk($sformatf("bp_count%0d", c), 32'(dut.count), bp_count[c]);
      chk($sformatf("bp_valid%0d", c), 32'(wakeup_valid), 3);
      chk($sformatf("bp_p0_%0d", c), 32'(wakeup_pdst[0]), 32'(exp_tags[2 * c]));
      chk($sformatf("bp_p1_%0d", c), 32'(wakeup_pdst[1]), 32'(exp_tags[2 * c + 1]));
    end
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    for (int c = 10; c < 12; c++) begin
      chk($sformatf("drain_ready%0d", c), 32'(fu_ready), 1);
      tick();
      chk($sformatf("drain_valid%0d", c), 32'(wakeup_valid), 3);
      chk($sformatf("drain_p0_%0d", c), 32'(wakeup_pdst[0]), 32'(exp_tags[2 * c]));
      chk($sformatf("drain_p1_%0d", c), 32'(wakeup_pdst[1]), 32'(exp_tags[2 * c + 1]));
    end
    chk("drain_count", 32'(dut.count), 0);
    tick();
    chk("drain_idle", 32'(wakeup_valid), 0);

    drive(4'b0111, 7'd0, 7'd7, 7'd7, 7'd0);
    tick();
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("dup_valid", 32'(wakeup_valid), 3);
    chk("dup_p0", 32'(wakeup_pdst[0]), 7);
    chk("dup_p1", 32'(wakeup_pdst[1]), 7);
    chk("dup_count", 32'(dut.count), 0);
    tick();
    chk("dup_idle", 32'(wakeup_valid), 0);

    drive(4'b1111, 7'd40, 7'd41, 7'd42, 7'd43);
    tick();
    drive(4'b1111, 7'd44, 7'd45, 7'd46, 7'd47);
    tick();
    chk("preflush_count", 32'(dut.count), 4);
    chk("preflush_p0", 32'(wakeup_pdst[0]), 42);
    drive(4'b0001, 7'd9, 7'd0, 7'd0, 7'd0);
    flush_pipelines = 1'b1;
    tick();
    flush_pipelines = 1'b0;
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("flush_valid", 32'(wakeup_valid), 0);
    chk("flush_count", 32'(dut.count), 0);
    chk("flush_ready", 32'(fu_ready), 1);
    tick();
    chk("postflush_valid1", 32'(wakeup_valid), 0);
    chk("postflush_count", 32'(dut.count), 0);
    tick();
    chk("postflush_valid2", 32'(wakeup_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
